// File: rtl/sh2_wb_sched_if.sv
`default_nettype none
// ============================================================================
// sh2_wb_sched_if : pipeline, load-return and register-file write port bundle
// Revision 1.0
// ============================================================================
interface sh2_wb_sched_if;
   logic        CE;
   logic        EN;
   logic        ALU_WE;
   logic [4:0]  ALU_ADDR;
   logic [31:0] ALU_D;
   logic        LD_ISSUE;
   logic [4:0]  LD_ADDR;
   logic        LD_RDY;
   logic [31:0] LD_D;
   logic        SRC_A_USE;
   logic [4:0]  SRC_A_ADDR;
   logic        SRC_B_USE;
   logic [4:0]  SRC_B_ADDR;
   logic        WAE;
   logic [4:0]  WA_ADDR;
   logic [31:0] WA_D;
   logic        WBE;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_D;
   logic        STALL;
   logic        FULL;
   logic        ERR;

   modport master (
      output CE, EN, ALU_WE, ALU_ADDR, ALU_D, LD_ISSUE, LD_ADDR, LD_RDY, LD_D,
             SRC_A_USE, SRC_A_ADDR, SRC_B_USE, SRC_B_ADDR,
      input  WAE, WA_ADDR, WA_D, WBE, WB_ADDR, WB_D, STALL, FULL, ERR
   );

   modport slave (
      input  CE, EN, ALU_WE, ALU_ADDR, ALU_D, LD_ISSUE, LD_ADDR, LD_RDY, LD_D,
             SRC_A_USE, SRC_A_ADDR, SRC_B_USE, SRC_B_ADDR,
      output WAE, WA_ADDR, WA_D, WBE, WB_ADDR, WB_D, STALL, FULL, ERR
   );
endinterface
`default_nettype wire

// File: rtl/sh2_wb_sched.sv
`default_nettype none
// ============================================================================
// sh2_wb_sched : SH2 writeback scheduler (ALU on port A, queued loads on port B)
// Revision 1.0
// ============================================================================
module sh2_wb_sched #(
   parameter int DEPTH = 2
) (
   input  wire logic     CLK,
   input  wire logic     RST_N,
   sh2_wb_sched_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [4:0]    mem_q [DEPTH];
   logic [4:0]    mem_d [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          rb_valid_q, rb_valid_d;
   logic [4:0]    rb_addr_q, rb_addr_d;
   logic [31:0]   rb_data_q, rb_data_d;
   logic          err_q, err_d;

   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          pop;
   logic          bad_rdy;
   logic          push;
   logic          drain;
   logic          stall;
   logic [31:0]   busy;

   always_comb begin
      count = wr_ptr_q - rd_ptr_q;
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

      // One bit per architectural register: set while a load still owes it data.
      busy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((AW+1)'(k) < count)
            busy[mem_q[rd_ptr_q[AW-1:0] + AW'(k)]] = 1'b1;
      end
      if (rb_valid_q)
         busy[rb_addr_q] = 1'b1;

      pop     = bus.LD_RDY & bus.EN & ~empty & ~(rb_valid_q & ~bus.CE);
      bad_rdy = bus.LD_RDY & bus.EN & (empty | (rb_valid_q & ~bus.CE));

      // A pop in the same cycle frees a slot, so a full FIFO need not block issue.
      stall = (bus.SRC_A_USE & busy[bus.SRC_A_ADDR]) |
              (bus.SRC_B_USE & busy[bus.SRC_B_ADDR]) |
              (bus.ALU_WE    & busy[bus.ALU_ADDR])   |
              (bus.LD_ISSUE  & full & ~pop);
      push  = bus.LD_ISSUE & bus.CE & bus.EN & ~stall;
      drain = rb_valid_q & bus.CE & bus.EN;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = bus.LD_ADDR;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end

      rb_valid_d = rb_valid_q;
      rb_addr_d  = rb_addr_q;
      rb_data_d  = rb_data_q;
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
         rb_valid_d = 1'b1;
         rb_addr_d  = mem_q[rd_ptr_q[AW-1:0]];
         rb_data_d  = bus.LD_D;
      end else if (drain) begin
         rb_valid_d = 1'b0;
      end

      err_d = err_q | bad_rdy;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rb_valid_q <= 1'b0;
         rb_addr_q  <= '0;
         rb_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rb_valid_q <= rb_valid_d;
         rb_addr_q  <= rb_addr_d;
         rb_data_q  <= rb_data_d;
         err_q      <= err_d;
      end
   end

   assign bus.WAE     = bus.ALU_WE & bus.CE & bus.EN & ~stall;
   assign bus.WA_ADDR = bus.ALU_ADDR;
   assign bus.WA_D    = bus.ALU_D;
   assign bus.WBE     = drain;
   assign bus.WB_ADDR = rb_addr_q;
   assign bus.WB_D    = rb_data_q;
   assign bus.STALL   = stall;
   assign bus.FULL    = full;
   assign bus.ERR     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_sh2_wb_sched.sv
`default_nettype none
// ============================================================================
// tb_sh2_wb_sched : vector table, directed corner sequences and random traffic
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sh2_wb_sched;
   localparam int DEPTH = 2;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   sh2_wb_sched_if bus();
   sh2_wb_sched #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

   typedef struct {
      logic ce, en, alu_we; logic [4:0] alu_addr; logic [31:0] alu_d;
      logic ld_issue; logic [4:0] ld_addr; logic ld_rdy; logic [31:0] ld_d;
      logic sa_use; logic [4:0] sa_addr; logic sb_use; logic [4:0] sb_addr;
   } in_t;
   typedef struct {
      logic wae; logic [4:0] wa_addr; logic [31:0] wa_d;
      logic wbe; logic [4:0] wb_addr; logic [31:0] wb_d;
      logic stall, full, err;
   } out_t;
   typedef struct { in_t i; out_t o; } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending destinations as a queue, one return slot, sticky error.
   logic [4:0]  m_pend[$];
   bit          m_rbv;
   logic [4:0]  m_rba;
   logic [31:0] m_rbd;
   bit          m_err;

   function automatic void m_clear();
      m_pend.delete(); m_rbv = 0; m_rba = '0; m_rbd = '0; m_err = 0;
   endfunction

   function automatic bit m_busy(input logic [4:0] a);
      foreach (m_pend[k]) if (m_pend[k] == a) return 1'b1;
      return m_rbv && (m_rba == a);
   endfunction

   function automatic out_t model_expect(input in_t x);
      out_t o;
      bit   full_m, pop_m;
      full_m = (m_pend.size() == DEPTH);
      pop_m  = x.ld_rdy && x.en && (m_pend.size() > 0) && !(m_rbv && !x.ce);
      o.stall = (x.sa_use && m_busy(x.sa_addr)) || (x.sb_use && m_busy(x.sb_addr)) ||
                (x.alu_we && m_busy(x.alu_addr)) || (x.ld_issue && full_m && !pop_m);
      o.wae = x.alu_we && x.ce && x.en && !o.stall;
      o.wa_addr = x.alu_addr;
      o.wa_d = x.alu_d;
      o.wbe = m_rbv && x.ce && x.en;
      o.wb_addr = m_rba;
      o.wb_d = m_rbd;
      o.full = full_m;
      o.err = m_err;
      return o;
   endfunction

   function automatic void model_step(input in_t x);
      out_t o;
      bit   pop_m;
      o = model_expect(x);
      if (!x.en) return;
      pop_m = x.ld_rdy && (m_pend.size() > 0) && !(m_rbv && !x.ce);
      if (pop_m) begin
         m_rba = m_pend.pop_front(); m_rbd = x.ld_d; m_rbv = 1;
      end else begin
         if (x.ld_rdy) m_err = 1;
         if (m_rbv && x.ce) m_rbv = 0;
      end
      if (x.ld_issue && x.ce && !o.stall) m_pend.push_back(x.ld_addr);
   endfunction

   function automatic in_t mk_in(bit ce, bit en, bit aw, logic [4:0] aa, logic [31:0] ad,
                                 bit li, logic [4:0] la, bit lr, logic [31:0] ld,
                                 bit su, logic [4:0] sa, bit tu, logic [4:0] sb);
      in_t x;
      x.ce = ce; x.en = en; x.alu_we = aw; x.alu_addr = aa; x.alu_d = ad;
      x.ld_issue = li; x.ld_addr = la; x.ld_rdy = lr; x.ld_d = ld;
      x.sa_use = su; x.sa_addr = sa; x.sb_use = tu; x.sb_addr = sb;
      return x;
   endfunction

   function automatic out_t mk_out(bit wae, logic [4:0] waa, logic [31:0] wad, bit wbe,
                                   logic [4:0] wba, logic [31:0] wbd, bit st, bit fu, bit er);
      out_t o;
      o.wae = wae; o.wa_addr = waa; o.wa_d = wad; o.wbe = wbe; o.wb_addr = wba;
      o.wb_d = wbd; o.stall = st; o.full = fu; o.err = er;
      return o;
   endfunction

   function automatic in_t idle(bit ce);
      return mk_in(ce, 1, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 0, 5'd0);
   endfunction

   function automatic logic [4:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 8);
      return (r == 8) ? 5'd16 : 5'(r);
   endfunction

   function automatic in_t rand_in();
      in_t x;
      x.ce = 1'($urandom_range(0, 1));
      x.en = ($urandom_range(0, 9) != 0);
      x.alu_we = 1'($urandom_range(0, 1));
      x.alu_addr = rand_addr();
      x.alu_d = $urandom();
      x.ld_issue = ($urandom_range(0, 2) == 0);
      x.ld_addr = rand_addr();
      x.ld_rdy = ($urandom_range(0, 3) == 0);
      x.ld_d = $urandom();
      x.sa_use = 1'($urandom_range(0, 1));
      x.sa_addr = rand_addr();
      x.sb_use = 1'($urandom_range(0, 1));
      x.sb_addr = rand_addr();
      return x;
   endfunction

   task automatic apply(input in_t x);
      bus.CE = x.ce; bus.EN = x.en; bus.ALU_WE = x.alu_we; bus.ALU_ADDR = x.alu_addr;
      bus.ALU_D = x.alu_d; bus.LD_ISSUE = x.ld_issue; bus.LD_ADDR = x.ld_addr;
      bus.LD_RDY = x.ld_rdy; bus.LD_D = x.ld_d; bus.SRC_A_USE = x.sa_use;
      bus.SRC_A_ADDR = x.sa_addr; bus.SRC_B_USE = x.sb_use; bus.SRC_B_ADDR = x.sb_addr;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input out_t e);
      chk({tag, ".wae"},     32'(bus.WAE),     32'(e.wae));
      chk({tag, ".wa_addr"}, 32'(bus.WA_ADDR), 32'(e.wa_addr));
      chk({tag, ".wa_d"},    bus.WA_D,         e.wa_d);
      chk({tag, ".wbe"},     32'(bus.WBE),     32'(e.wbe));
      chk({tag, ".wb_addr"}, 32'(bus.WB_ADDR), 32'(e.wb_addr));
      chk({tag, ".wb_d"},    bus.WB_D,         e.wb_d);
      chk({tag, ".stall"},   32'(bus.STALL),   32'(e.stall));
      chk({tag, ".full"},    32'(bus.FULL),    32'(e.full));
      chk({tag, ".err"},     32'(bus.ERR),     32'(e.err));
   endtask

   // Entered at posedge+1: drive, compare mid-cycle, advance model and clock.
   task automatic run(input in_t x, input string tag);
      apply(x); #3;
      cmp_all(tag, model_expect(x));
      model_step(x);
      @(posedge CLK); #1;
   endtask

   task automatic run_tbl(input vec_t v, input string tag);
      apply(v.i); #3;
      cmp_all(tag, v.o);
      model_step(v.i);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      in_t  x;

      tbl[0]  = '{mk_in(0,1,0,5'd0,32'd0,0,5'd0,0,32'd0,0,5'd0,0,5'd0), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[1]  = '{mk_in(1,1,1,5'd3,32'hDEADBEEF,0,5'd0,0,32'd0,0,5'd0,0,5'd0), mk_out(1,5'd3,32'hDEADBEEF,0,5'd0,32'd0,0,0,0)};
      tbl[2]  = '{mk_in(1,1,0,5'd0,32'd0,1,5'd5,0,32'd0,0,5'd0,0,5'd0), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[3]  = '{idle(0), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[4]  = '{idle(1), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[5]  = '{idle(0), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[6]  = '{mk_in(1,1,0,5'd0,32'd0,0,5'd0,1,32'h12345678,0,5'd0,0,5'd0), mk_out(0,5'd0,32'd0,0,5'd0,32'd0,0,0,0)};
      tbl[7]  = '{idle(0), mk_out(0,5'd0,32'd0,0,5'd5,32'h12345678,0,0,0)};
      tbl[8]  = '{idle(1), mk_out(0,5'd0,32'd0,1,5'd5,32'h12345678,0,0,0)};
      tbl[9]  = '{idle(0), mk_out(0,5'd0,32'd0,0,5'd5,32'h12345678,0,0,0)};
      tbl[10] = '{mk_in(1,1,0,5'd0,32'd0,1,5'd2,0,32'd0,0,5'd0,0,5'd0), mk_out(0,5'd0,32'd0,0,5'd5,32'h12345678,0,0,0)};
      tbl[11] = '{mk_in(1,1,1,5'd2,32'hA5A5A5A5,0,5'd0,0,32'd0,1,5'd2,0,5'd0), mk_out(0,5'd2,32'hA5A5A5A5,0,5'd5,32'h12345678,1,0,0)};
      tbl[12] = '{mk_in(1,1,1,5'd2,32'hA5A5A5A5,0,5'd0,1,32'h0BADF00D,1,5'd2,0,5'd0), mk_out(0,5'd2,32'hA5A5A5A5,0,5'd5,32'h12345678,1,0,0)};
      tbl[13] = '{mk_in(1,1,1,5'd2,32'hA5A5A5A5,0,5'd0,0,32'd0,1,5'd2,0,5'd0), mk_out(0,5'd2,32'hA5A5A5A5,1,5'd2,32'h0BADF00D,1,0,0)};
      tbl[14] = '{mk_in(1,1,1,5'd2,32'hA5A5A5A5,0,5'd0,0,32'd0,1,5'd2,0,5'd0), mk_out(1,5'd2,32'hA5A5A5A5,0,5'd2,32'h0BADF00D,0,0,0)};
      tbl[15] = '{mk_in(0,0,1,5'd7,32'h77,0,5'd0,0,32'd0,0,5'd0,0,5'd0), mk_out(0,5'd7,32'h77,0,5'd2,32'h0BADF00D,0,0,0)};

      m_clear();
      apply(idle(0));
      #2;
      chk("rst_full", 32'(bus.FULL), 32'd0);
      chk("rst_err", 32'(bus.ERR), 32'd0);
      chk("rst_wbe", 32'(bus.WBE), 32'd0);
      #10 RST_N = 1'b1;
      @(posedge CLK); #1;

      for (int r = 0; r < 16; r++)
         run_tbl(tbl[r], $sformatf("tbl%0d", r));

      // FULL, third-load stall, pop-then-push and in-order returns.
      x = idle(1); x.ld_issue = 1; x.ld_addr = 5'd1; run(x, "push_r1");
      x.ld_addr = 5'd4; run(x, "push_r4");
      chk("full_set", 32'(bus.FULL), 32'd1);
      x = idle(0); x.sb_use = 1; x.sb_addr = 5'd4; run(x, "raw_b");
      chk("raw_b_stall", 32'(bus.STALL), 32'd1);
      x = idle(1); x.ld_issue = 1; x.ld_addr = 5'd9; run(x, "third_held");
      chk("third_stall", 32'(bus.STALL), 32'd1);
      x = idle(0); x.ld_issue = 1; x.ld_addr = 5'd9; x.ld_rdy = 1; x.ld_d = 32'h11111111;
      run(x, "pop_r1");
      chk("full_clear", 32'(bus.FULL), 32'd0);
      x = idle(1); x.ld_issue = 1; x.ld_addr = 5'd9; run(x, "push_r9");
      chk("wb_r1_addr", 32'(bus.WB_ADDR), 32'd1);
      x = idle(0); x.ld_rdy = 1; x.ld_d = 32'h44444444; run(x, "ret_r4");
      x = idle(1); x.ld_rdy = 1; x.ld_d = 32'h99999999; run(x, "drain_reload");
      chk("reload_addr", 32'(bus.WB_ADDR), 32'd9);
      x = idle(1); run(x, "wb_r9");
      chk("wb_r9_data", bus.WB_D, 32'h99999999);
      chk("empty_full", 32'(bus.FULL), 32'd0);

      // Stray return sets a sticky error; async reset clears everything mid-queue.
      x = idle(1); x.ld_rdy = 1; x.ld_d = 32'hBAD00000; run(x, "rdy_empty");
      chk("err_set", 32'(bus.ERR), 32'd1);
      x = idle(1); run(x, "err_hold");
      chk("err_wbe", 32'(bus.WBE), 32'd0);
      chk("err_sticky", 32'(bus.ERR), 32'd1);
      x = idle(1); x.ld_issue = 1; x.ld_addr = 5'd6; run(x, "push_r6");
      x.ld_addr = 5'd7; run(x, "push_r7");
      x = idle(0); x.sa_use = 1; x.sa_addr = 5'd6; apply(x);
      #1;
      chk("pre_rst_full", 32'(bus.FULL), 32'd1);
      chk("pre_rst_stall", 32'(bus.STALL), 32'd1);
      RST_N = 1'b0; m_clear();
      #1;
      chk("async_full", 32'(bus.FULL), 32'd0);
      chk("async_err", 32'(bus.ERR), 32'd0);
      chk("async_stall", 32'(bus.STALL), 32'd0);
      #2 RST_N = 1'b1;
      @(posedge CLK); #1;
      x = idle(1); x.ld_rdy = 1; x.ld_d = 32'h5A5A5A5A; run(x, "late_rdy");
      chk("late_err", 32'(bus.ERR), 32'd1);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            RST_N = 1'b0; m_clear();
            #1 RST_N = 1'b1;
         end
         run(rand_in(), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sh2_wb_sched.md
# sh2_wb_sched

Writeback scheduler that drives both write ports of the SH2 register file. ALU results go to the immediate port A in the CE cycle that produces them. Load data returns from the bus interface at arbitrary cycles and is queued onto the latched port B. A load-destination scoreboard stalls the pipeline on read-after-load and write-after-load hazards.

## Interface
Parameters:
- DEPTH, 2: maximum outstanding loads (pending-destination FIFO depth, power of two, 2..4).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE  in  1  pipeline advance strobe. The register file accepts port A only when CE=1 and latches port B on CE.
- EN  in  1  global enable. When 0, all state holds and WAE=WBE=0.
- ALU_WE  in  1  ALU result valid this cycle.
- ALU_ADDR  in  5  ALU destination (16 = PR).
- ALU_D  in  32  ALU result.
- LD_ISSUE  in  1  load issued this CE cycle.
- LD_ADDR  in  5  load destination.
- LD_RDY  in  1  load data returned (one-cycle pulse).
- LD_D  in  32  returned load data.
- SRC_A_USE, SRC_B_USE  in  1  decode reads source A/B.
- SRC_A_ADDR, SRC_B_ADDR  in  5  decode source registers.
- WAE  out  1  port A write enable.
- WA_ADDR  out  5  port A address.
- WA_D  out  32  port A data.
- WBE  out  1  port B write enable.
- WB_ADDR  out  5  port B address.
- WB_D  out  32  port B data.
- STALL  out  1  hazard; hold decode and issue.
- FULL  out  1  DEPTH loads outstanding.
- ERR  out  1  sticky protocol error.

## Operation
- Pending FIFO holds destination addresses of issued loads. Push on LD_ISSUE & CE & ~STALL & EN. Pop when the return buffer is loaded.
- Return buffer is one entry: RB_VALID, RB_ADDR, RB_D.
  - LD_RDY with a non-empty FIFO loads the buffer from the FIFO head and LD_D.
  - The buffer drains (RB_VALID←0) on a CE cycle.
- Port A is combinational: WAE = ALU_WE & CE & EN & ~STALL; WA_ADDR = ALU_ADDR; WA_D = ALU_D.
- Port B is registered from the buffer: WBE = RB_VALID & CE & EN; WB_ADDR = RB_ADDR; WB_D = RB_D.
- Scoreboard: a register is busy if it matches any valid FIFO entry or the return buffer while RB_VALID. STALL is asserted when any of these holds:
  - SRC_A_USE and SRC_A_ADDR is busy;
  - SRC_B_USE and SRC_B_ADDR is busy;
  - ALU_WE and ALU_ADDR is busy (write-after-load);
  - LD_ISSUE and FULL.
- Because of the write-after-load stall, ports A and B never target the same register in the same cycle.
- Addresses compare on all 5 bits; PR (16) is tracked like R0–R15.
- ERR is set by either of these, and the offending event is otherwise ignored:
  - LD_RDY with an empty FIFO;
  - LD_RDY while RB_VALID & ~CE (overrun).
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Empty: pointers equal.
  - FULL: the pointers' MSBs differ and the remaining bits are equal.
- Same-cycle push and pop are allowed, including at FULL. Occupancy is unchanged, and push is permitted when a pop occurs in the same cycle.

## Timing
- Reset values: FIFO empty, RB_VALID=0, ERR=0, STALL=0 (combinational, inputs low), FULL=0, WAE=WBE=0, WA/WB address and data 0.
- Port A latency: 0 cycles. The write is combinational from the ALU inputs.
- Load latency:
  - LD_RDY at cycle t loads the buffer at t+1.
  - WBE is asserted in the first CE cycle ≥ t+1.
  - The register file commits the data one cycle after that.
- Scoreboard clear: the busy bit clears the cycle after the buffer drains, so a dependent instruction's STALL drops one cycle after the WBE cycle.
- LD_RDY in the same cycle as a CE drain of the buffer is legal. The buffer reloads and RB_VALID stays 1.
- Reset mid-operation discards outstanding loads without writeback. Late LD_RDY pulses after reset set ERR.

## Test plan
- ALU_WE=1, ALU_ADDR=3, ALU_D=0xDEADBEEF, CE=1, no loads -> WAE=1, WA_ADDR=3, WA_D=0xDEADBEEF in the same cycle; WBE=0.
- LD_ISSUE to R5; LD_RDY 4 cycles later with LD_D=0x12345678 while CE toggles every other cycle -> single WBE with WB_ADDR=5, WB_D=0x12345678 on the first CE after capture; FIFO empty afterwards.
- Load to R2 outstanding; decode SRC_A_USE with SRC_A_ADDR=2 -> STALL=1 until the cycle after WBE, then 0; an ALU write to R2 is held (WAE=0) for the same window.
- DEPTH=2: issue loads to R1 and R4 -> FULL=1; a third LD_ISSUE raises STALL; LD_RDY pops R1, then FULL=0 and the third load pushes on the next CE; returns write R1, R4, R-third in order.
- LD_RDY with no outstanding loads -> ERR=1 sticky, WBE stays 0; RST_N low mid-queue -> FIFO empty, FULL=0, ERR=0 immediately (asynchronous).
